// File: rtl/pmu_pkg.sv
// pmu_pkg: definitions shared by the PMU sweep collector and the code around it.
//   CNT_NUM_DFLT    - counters per PMU (counter addresses 0..18).
//   CNT_ADDR_W      - width of the broadcast counter address.
//   CNT_ADDR_IDLE   - address of the read-idle counter (first in a sweep). The
//                     last default address, 18, is the clock counter.
//   sweep_state_e   - collector sequencing states.
//   pmu_rec_user_t  - record sideband layout for the default 4-PMU build.
package pmu_pkg;

  localparam int CNT_NUM_DFLT    = 19;
  localparam int CNT_ADDR_W      = 5;
  localparam int PMU_IDX_W_DFLT  = 2;

  localparam logic [CNT_ADDR_W-1:0] CNT_ADDR_IDLE = 5'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAST = 2'd2
  } sweep_state_e;

  typedef struct packed {
    logic                      is_header;
    logic [PMU_IDX_W_DFLT-1:0] pmu_idx;
    logic [CNT_ADDR_W-1:0]     cnt_idx;
  } pmu_rec_user_t;

endpackage

// File: rtl/pmu_interval_timer.sv
// pmu_interval_timer: free-running periodic trigger source.
//   aclk, aresetn - clock, async active-low reset
//   i_en          - timer enable; low clears the count
//   i_interval    - period in cycles; 0 disables the timer
//   o_expire      - one-cycle pulse every i_interval cycles while enabled
module pmu_interval_timer #(
  parameter int INTERVAL_W = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  i_en,
  input  logic [INTERVAL_W-1:0] i_interval,
  output logic                  o_expire
);

  logic [INTERVAL_W-1:0] r_cnt;
  logic                  w_run;

  assign w_run = i_en && (i_interval != '0);
  // >= rather than == so that lowering the interval below the current count
  // still produces an expiry instead of waiting for a full counter wrap.
  assign o_expire = w_run && (r_cnt >= (i_interval - 1'b1));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cnt <= '0;
    end else if (!w_run || o_expire) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pmu_sweep_collector.sv
// pmu_sweep_collector: sweeps every counter of NUM_PMU PMUs sharing one
// broadcast counter address and streams a header plus NUM_PMU*CNT_NUM records.
//   aclk, aresetn            - clock, async active-low reset
//   start_i                  - one-cycle sweep trigger
//   periodic_en_i/interval_i - periodic trigger control (interval 0 = off)
//   clear_i                  - clears the sticky overrun flag
//   pmu_addr_o/pmu_data_i    - broadcast counter address, per-PMU data (64b each)
//   m_tvalid/m_tready/m_tdata/m_tuser/m_tlast - record stream
//     m_tuser = {is_header, pmu_idx, cnt_idx}
//   busy_o, overrun_o, sweep_seq_o - status
//
// state   | meaning
// IDLE    | no sweep; a trigger loads the header beat
// RUN     | header or records in flight, next record loads when register frees
// LAST    | final record held until accepted
module pmu_sweep_collector
  import pmu_pkg::*;
#(
  parameter int NUM_PMU    = 4,
  parameter int CNT_NUM    = CNT_NUM_DFLT,
  parameter int INTERVAL_W = 32,
  parameter int PMU_IDX_W  = (NUM_PMU > 1) ? $clog2(NUM_PMU) : 1
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          start_i,
  input  logic                          periodic_en_i,
  input  logic [INTERVAL_W-1:0]         interval_i,
  input  logic                          clear_i,
  output logic [CNT_ADDR_W-1:0]         pmu_addr_o,
  input  logic [NUM_PMU*64-1:0]         pmu_data_i,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic [63:0]                   m_tdata,
  output logic [PMU_IDX_W+CNT_ADDR_W:0] m_tuser,
  output logic                          m_tlast,
  output logic                          busy_o,
  output logic                          overrun_o,
  output logic [31:0]                   sweep_seq_o
);

  localparam int USER_W = 1 + PMU_IDX_W + CNT_ADDR_W;
  localparam logic [31:0]           REC_TOTAL = 32'(NUM_PMU * CNT_NUM);
  localparam logic [PMU_IDX_W-1:0]  P_LAST    = PMU_IDX_W'(NUM_PMU - 1);
  localparam logic [CNT_ADDR_W-1:0] C_LAST    = CNT_ADDR_W'(CNT_NUM - 1);

  sweep_state_e            r_state, w_state_nxt;
  logic [PMU_IDX_W-1:0]    r_p;
  logic [CNT_ADDR_W-1:0]   r_c;
  logic                    r_tvalid, r_tlast, r_overrun;
  logic [63:0]             r_tdata;
  logic [USER_W-1:0]       r_tuser;
  logic [31:0]             r_seq;
  logic [63:0]             w_rec;
  logic                    w_expire, w_trig, w_drop, w_free, w_at_last;
  logic                    w_load_hdr, w_load_rec, w_done;

  pmu_interval_timer #(
    .INTERVAL_W(INTERVAL_W)
  ) u_timer (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .i_en      (periodic_en_i),
    .i_interval(interval_i),
    .o_expire  (w_expire)
  );

  // PMUs answer combinationally, so the slice seen now belongs to address r_c.
  assign w_rec     = pmu_data_i[r_p*64 +: 64];
  assign w_trig    = start_i || w_expire;
  assign w_drop    = w_trig && (r_state != ST_IDLE);
  assign w_free    = !r_tvalid || m_tready;
  assign w_at_last = (r_p == P_LAST) && (r_c == C_LAST);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_hdr  = 1'b0;
    w_load_rec  = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_trig) begin
          w_load_hdr  = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_free) begin
          w_load_rec = 1'b1;
          if (w_at_last) w_state_nxt = ST_LAST;
        end
      end
      ST_LAST: begin
        if (r_tvalid && m_tready) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_tvalid  <= 1'b0;
      r_tdata   <= '0;
      r_tuser   <= '0;
      r_tlast   <= 1'b0;
      r_p       <= '0;
      r_c       <= CNT_ADDR_IDLE;
      r_seq     <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_load_hdr) begin
        r_tvalid <= 1'b1;
        r_tdata  <= {r_seq, REC_TOTAL};
        r_tuser  <= {1'b1, {(USER_W-1){1'b0}}};
        r_tlast  <= 1'b0;
        r_p      <= '0;
        r_c      <= CNT_ADDR_IDLE;
      end else if (w_load_rec) begin
        r_tvalid <= 1'b1;
        r_tdata  <= w_rec;
        r_tuser  <= {1'b0, r_p, r_c};
        r_tlast  <= w_at_last;
        if (r_c == C_LAST) begin
          r_c <= CNT_ADDR_IDLE;
          r_p <= w_at_last ? '0 : r_p + 1'b1;
        end else begin
          r_c <= r_c + 1'b1;
        end
      end else if (w_done) begin
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
        r_seq    <= r_seq + 1'b1;
      end
      // A dropped trigger outranks a same-cycle clear.
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (clear_i) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign pmu_addr_o  = r_c;
  assign m_tvalid    = r_tvalid;
  assign m_tdata     = r_tdata;
  assign m_tuser     = r_tuser;
  assign m_tlast     = r_tlast;
  assign busy_o      = (r_state != ST_IDLE);
  assign overrun_o   = r_overrun;
  assign sweep_seq_o = r_seq;

endmodule

// File: tb/tb_pmu_sweep_collector.sv
// Bench for pmu_sweep_collector: transaction-level model of sweeps, triggers,
// overrun and sequence number, driven one cycle at a time from a single process.
module tb_pmu_sweep_collector;
  import pmu_pkg::*;

  localparam int NP = 4;
  localparam int CN = 19;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic              start_i, periodic_en_i, clear_i, m_tready;
  logic [31:0]       interval_i;
  logic [4:0]        pmu_addr_o;
  logic [NP*64-1:0]  pmu_data_i;
  logic              m_tvalid, m_tlast, busy_o, overrun_o;
  logic [63:0]       m_tdata;
  logic [7:0]        m_tuser;
  logic [31:0]       sweep_seq_o;

  always #5 aclk = ~aclk;

  pmu_sweep_collector #(.NUM_PMU(NP), .CNT_NUM(CN), .INTERVAL_W(32)) dut (
    .aclk(aclk), .aresetn(aresetn), .start_i(start_i), .periodic_en_i(periodic_en_i),
    .interval_i(interval_i), .clear_i(clear_i), .pmu_addr_o(pmu_addr_o),
    .pmu_data_i(pmu_data_i), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tlast(m_tlast), .busy_o(busy_o),
    .overrun_o(overrun_o), .sweep_seq_o(sweep_seq_o)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  user;
    logic        last;
  } beat_t;

  typedef struct {
    int          k;
    logic        is_hdr;
    int          p;
    int          c;
    logic [7:0]  user;
    logic        last;
  } probe_t;

  int          checks, failures;
  logic [31:0] salt;
  beat_t       exp_q[$];
  beat_t       log_q[$];
  beat_t       held;
  logic        held_v;
  logic        m_busy, pend_idle, pend_set, pend_clr, pend_seq, exp_ov;
  logic [31:0] exp_seq;
  int unsigned tmr;
  int          rdy_mode, n_acc;
  logic        drv_en;
  logic [31:0] drv_int;
  probe_t      tbl[6];

  // PMU counter model: distinct per PMU, address and sweep (salt).
  function automatic logic [63:0] pmu_val(input int p, input logic [4:0] a, input logic [31:0] s);
    logic [31:0] hi, lo;
    hi = (32'hC0DE_0000 | (32'(p) << 8)) ^ s;
    lo = {s[15:0], 3'b000, 8'(p), a};
    return {hi, lo};
  endfunction

  for (genvar g = 0; g < NP; g++) begin : g_pmu
    assign pmu_data_i[g*64 +: 64] = pmu_val(g, pmu_addr_o, salt);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic push_sweep();
    pmu_rec_user_t u;
    beat_t b;
    salt = $urandom;
    u = '{1'b1, 2'd0, 5'd0};
    b = '{{exp_seq, 32'(NP*CN)}, u, 1'b0};
    exp_q.push_back(b);
    for (int p = 0; p < NP; p++) begin
      for (int c = 0; c < CN; c++) begin
        u = '{1'b0, 2'(p), 5'(c)};
        b = '{pmu_val(p, 5'(c), salt), u, (p == NP-1) && (c == CN-1)};
        exp_q.push_back(b);
      end
    end
  endtask

  // One clock: check state implied by the previous edge, pick tready, log the
  // beat that the coming edge accepts, then drive triggers for that edge.
  task automatic cycle(input logic st, input logic clr);
    beat_t cur, e;
    logic trig;
    @(negedge aclk);
    if (pend_idle) begin m_busy = 1'b0; pend_idle = 1'b0; end
    if (pend_seq)  begin exp_seq = exp_seq + 1; pend_seq = 1'b0; end
    if (pend_set) exp_ov = 1'b1;
    else if (pend_clr) exp_ov = 1'b0;
    pend_set = 1'b0;
    pend_clr = 1'b0;
    chk("busy_o", busy_o, m_busy);
    chk("overrun_o", overrun_o, exp_ov);
    chk("sweep_seq_o", sweep_seq_o, exp_seq);
    cur = '{m_tdata, m_tuser, m_tlast};
    if (held_v) begin
      chk("stall_valid", m_tvalid, 1'b1);
      chk("stall_beat", cur, held);
    end
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = 1'($urandom_range(0, 1));
      default: m_tready = 1'b0;
    endcase
    if (m_tvalid && m_tready) begin
      log_q.push_back(cur);
      n_acc++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_beat actual=%h required=no beat", cur);
      end else begin
        e = exp_q.pop_front();
        chk("beat", cur, e);
      end
      if (m_tlast) begin pend_idle = 1'b1; pend_seq = 1'b1; end
    end
    held_v = m_tvalid && !m_tready;
    held   = cur;
    start_i       = st;
    clear_i       = clr;
    periodic_en_i = drv_en;
    interval_i    = drv_int;
    trig = st;
    if (drv_en && drv_int != 0) begin
      tmr++;
      if (tmr == drv_int) begin trig = 1'b1; tmr = 0; end
    end else begin
      tmr = 0;
    end
    if (trig) begin
      if (m_busy) pend_set = 1'b1;
      else begin m_busy = 1'b1; push_sweep(); end
    end
    pend_clr = clr;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n;
    n = 0;
    while ((m_busy || pend_idle || exp_q.size() != 0) && n < budget) begin
      cycle(1'b0, 1'b0);
      n++;
    end
    checks++;
    if (m_busy || pend_idle || exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s timeout after %0d cycles: pending beats=%0d required 0", nm, n, exp_q.size());
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; pend_idle = 1'b0; pend_set = 1'b0; pend_clr = 1'b0;
    pend_seq = 1'b0; exp_ov = 1'b0; exp_seq = '0; tmr = 0; held_v = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    logic [31:0] s0;
    int n;
    checks = 0; failures = 0; salt = 32'h1234_5678; n_acc = 0;
    rdy_mode = 0; drv_en = 1'b0; drv_int = '0;
    held = '0;
    model_reset();
    aresetn = 1'b0; start_i = 1'b0; periodic_en_i = 1'b0; interval_i = '0;
    clear_i = 1'b0; m_tready = 1'b0;

    // beat probes of the first sweep: {k, is_hdr, p, c, tuser, tlast}
    tbl[0] = '{0,  1'b1, 0, 0,  8'h80, 1'b0};
    tbl[1] = '{1,  1'b0, 0, 0,  8'h00, 1'b0};
    tbl[2] = '{19, 1'b0, 0, 18, 8'h12, 1'b0};
    tbl[3] = '{20, 1'b0, 1, 0,  8'h20, 1'b0};
    tbl[4] = '{45, 1'b0, 2, 6,  8'h46, 1'b0};
    tbl[5] = '{76, 1'b0, 3, 18, 8'h72, 1'b1};

    repeat (3) @(negedge aclk);
    chk("rst_tvalid", m_tvalid, 1'b0);
    chk("rst_tdata", m_tdata, 64'h0);
    chk("rst_tuser", m_tuser, 8'h0);
    chk("rst_tlast", m_tlast, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_overrun", overrun_o, 1'b0);
    chk("rst_seq", sweep_seq_o, 32'h0);
    chk("rst_addr", pmu_addr_o, 5'h0);
    aresetn = 1'b1;

    // single sweep, always ready
    log_q.delete();
    cycle(1'b1, 1'b0);
    wait_idle("sweep1", 300);
    chk("sweep1_beats", log_q.size(), 77);
    chk("sweep1_seq", sweep_seq_o, 32'd1);
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].k < log_q.size()) begin
        chk("probe_data", log_q[tbl[i].k].data,
            tbl[i].is_hdr ? 64'h0000_0000_0000_004C : pmu_val(tbl[i].p, 5'(tbl[i].c), salt));
        chk("probe_user", log_q[tbl[i].k].user, tbl[i].user);
        chk("probe_last", log_q[tbl[i].k].last, tbl[i].last);
      end else begin
        checks++; failures++;
        $display("FAIL probe_missing beat %0d actual=%0d beats", tbl[i].k, log_q.size());
      end
    end

    // random backpressure
    rdy_mode = 1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0);
      wait_idle("bp_sweep", 1500);
    end

    // start during RUN is dropped and flagged
    rdy_mode = 0;
    s0 = sweep_seq_o;
    cycle(1'b1, 1'b0);
    repeat (10) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    wait_idle("run_start", 300);
    chk("run_start_overrun", overrun_o, 1'b1);
    chk("run_start_one_sweep", sweep_seq_o - s0, 32'd1);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    chk("clear_overrun", overrun_o, 1'b0);

    // periodic, interval 200
    s0 = sweep_seq_o;
    drv_en = 1'b1; drv_int = 32'd200;
    repeat (1000) cycle(1'b0, 1'b0);
    drv_en = 1'b0;
    wait_idle("per200", 300);
    chk("per200_sweeps", sweep_seq_o - s0, 32'd5);
    chk("per200_overrun", overrun_o, 1'b0);

    // periodic, interval 50: overlaps, sweeps keep going
    s0 = sweep_seq_o;
    drv_en = 1'b1; drv_int = 32'd50;
    repeat (600) cycle(1'b0, 1'b0);
    drv_en = 1'b0;
    wait_idle("per50", 300);
    chk("per50_overrun", overrun_o, 1'b1);
    chk("per50_progress", (sweep_seq_o - s0) >= 32'd4, 1'b1);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    chk("per50_clear", overrun_o, 1'b0);

    // random triggers, clears and backpressure
    rdy_mode = 1;
    for (int i = 0; i < 1500; i++)
      cycle(1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 99) < 5));
    wait_idle("random", 2000);

    // reset in the middle of a sweep
    rdy_mode = 0;
    n_acc = 0;
    cycle(1'b1, 1'b0);
    n = 0;
    while (n_acc < 30 && n < 200) begin cycle(1'b0, 1'b0); n++; end
    chk("reach_beat30", n_acc, 30);
    #1 aresetn = 1'b0;
    #1;
    chk("midrst_tvalid", m_tvalid, 1'b0);
    chk("midrst_tlast", m_tlast, 1'b0);
    chk("midrst_busy", busy_o, 1'b0);
    chk("midrst_seq", sweep_seq_o, 32'h0);
    model_reset();
    @(negedge aclk);
    aresetn = 1'b1;
    log_q.delete();
    cycle(1'b1, 1'b0);
    wait_idle("post_rst", 300);
    chk("post_rst_beats", log_q.size(), 77);
    chk("post_rst_hdr", log_q.size() > 0 ? log_q[0].data : 64'hX, 64'h0000_0000_0000_004C);
    chk("post_rst_seq", sweep_seq_o, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
